// File: rtl/cfg_chain_loader.sv
// Master end of the configuration shift chain: serialises host words onto the
// chain, then optionally recirculates it once and checks a ones-count signature.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 48,
  parameter int WORD_W    = 8,
  parameter int VERIFY    = 1
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              chain_prog_in,
  output logic              chain_prog_en,
  input  logic              chain_prog_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int ONES_W    = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W     = $clog2(WORD_W + 1);
  localparam int WCNT_W    = $clog2(NWORDS + 1);

  localparam logic [BIT_W-1:0]  WORD_IDX  = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0]  LAST_IDX  = BIT_W'(LAST_BITS - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
  localparam logic [ONES_W-1:0] VCNT_LAST = ONES_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   shift_reg, shift_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [WCNT_W-1:0]   word_cnt_reg, word_cnt_next;
  logic [ONES_W-1:0]   sent_ones_reg, sent_ones_next;
  logic [ONES_W-1:0]   seen_ones_reg, seen_ones_next;
  logic [ONES_W-1:0]   verify_cnt_reg, verify_cnt_next;
  logic                cfg_ready_reg, cfg_ready_next;
  logic                prog_en_reg, prog_en_next;
  logic                busy_reg, busy_next;
  logic                recirc_reg, recirc_next;
  logic                done_reg, done_next;
  logic                error_reg, error_next;
  logic                last_word;
  logic                last_bit;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_reg      <= S_IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      word_cnt_reg   <= '0;
      sent_ones_reg  <= '0;
      seen_ones_reg  <= '0;
      verify_cnt_reg <= '0;
      cfg_ready_reg  <= 1'b0;
      prog_en_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      recirc_reg     <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      word_cnt_reg   <= word_cnt_next;
      sent_ones_reg  <= sent_ones_next;
      seen_ones_reg  <= seen_ones_next;
      verify_cnt_reg <= verify_cnt_next;
      cfg_ready_reg  <= cfg_ready_next;
      prog_en_reg    <= prog_en_next;
      busy_reg       <= busy_next;
      recirc_reg     <= recirc_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    word_cnt_next   = word_cnt_reg;
    sent_ones_next  = sent_ones_reg;
    seen_ones_next  = seen_ones_reg;
    verify_cnt_next = verify_cnt_reg;
    last_word       = (word_cnt_reg == LAST_WORD);
    last_bit        = (bit_cnt_reg == (last_word ? LAST_IDX : WORD_IDX));

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_next      = S_WAIT_WORD;
          bit_cnt_next    = '0;
          word_cnt_next   = '0;
          sent_ones_next  = '0;
          seen_ones_next  = '0;
          verify_cnt_next = '0;
        end
      end
      S_WAIT_WORD: begin
        if (cfg_valid && cfg_ready_reg) begin
          shift_next   = cfg_data;
          bit_cnt_next = '0;
          state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sent_ones_next = sent_ones_reg + ONES_W'(shift_reg[0]);
        shift_next     = shift_reg >> 1;
        bit_cnt_next   = bit_cnt_reg + BIT_W'(1);
        if (last_bit) begin
          // Clearing the shift register keeps chain_prog_in low between words.
          shift_next      = '0;
          bit_cnt_next    = '0;
          word_cnt_next   = word_cnt_reg + WCNT_W'(1);
          verify_cnt_next = '0;
          if (last_word) begin
            state_next = (VERIFY != 0) ? S_VERIFY : S_DONE;
          end else begin
            state_next = S_WAIT_WORD;
          end
        end
      end
      S_VERIFY: begin
        seen_ones_next  = seen_ones_reg + ONES_W'(chain_prog_out);
        verify_cnt_next = verify_cnt_reg + ONES_W'(1);
        if (verify_cnt_reg == VCNT_LAST) begin
          state_next = (seen_ones_next == sent_ones_reg) ? S_DONE : S_ERROR;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (abort) begin
      state_next      = S_IDLE;
      shift_next      = '0;
      bit_cnt_next    = '0;
      word_cnt_next   = '0;
      verify_cnt_next = '0;
    end

    // Outputs are decoded from the next state so they leave flops directly.
    cfg_ready_next = (state_next == S_WAIT_WORD);
    prog_en_next   = (state_next == S_SHIFT) || (state_next == S_VERIFY);
    busy_next      = (state_next == S_WAIT_WORD) || (state_next == S_SHIFT) ||
                     (state_next == S_VERIFY);
    recirc_next    = (state_next == S_VERIFY);
    done_next      = (state_next == S_DONE);
    error_next     = (state_next == S_ERROR);
  end

  assign cfg_ready     = cfg_ready_reg;
  assign chain_prog_en = prog_en_reg;
  assign chain_prog_in = recirc_reg ? chain_prog_out : shift_reg[0];
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Master end of the configuration shift chain. It takes configuration words from a host over a valid/ready handshake and serialises them onto the chain's prog_in/prog_en.
- It then recirculates the chain once through its prog_out tail and checks a ones-count signature, so a broken or mis-sized chain is detected.
- Sits between the bitstream source and the first block (io_block, etc.) of the chain. It runs on the same prog_clk as the chain.

Parameters:
- CHAIN_LEN, 48: total number of configuration bits in the chain (>= 1).
- WORD_W, 8: width of host configuration words (>= 1).
- VERIFY, 1: 1 enables the recirculate-and-check pass; 0 goes straight to DONE after load.

Ports:
- prog_clk  input  1  chain/loader clock; all state updates on its rising edge.
- prog_rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: begin a load; honoured only in IDLE, DONE or ERROR.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- cfg_data  input  WORD_W  configuration word.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader can accept a word.
- chain_prog_in  output  1  serial bit to the chain head.
- chain_prog_en  output  1  chain shift enable.
- chain_prog_out  input  1  serial bit from the chain tail (registered by the last cell).
- busy  output  1  high in WAIT_WORD, SHIFT, VERIFY.
- done  output  1  load (and verify, if enabled) completed successfully.
- error  output  1  verify signature mismatch.

Behaviour:
- Reset (async, prog_rst_n=0): state IDLE. cfg_ready, chain_prog_in, chain_prog_en, busy, done and error are all 0. All counters are 0.
- NWORDS = ceil(CHAIN_LEN/WORD_W). The last word uses only its low CHAIN_LEN-(NWORDS-1)*WORD_W bits; its upper bits are ignored.
- Bit order: word 0 first, LSB first within each word. The first bit shifted ends at the chain tail cell.
- States and transitions:
  - IDLE: all outputs 0. start -> WAIT_WORD, clearing done, error, the word counter and the ones counter.
  - WAIT_WORD: cfg_ready=1 and chain_prog_en=0. When cfg_valid&&cfg_ready, latch the word into the shift register -> SHIFT. No timeout.
  - SHIFT: cfg_ready=0. chain_prog_en=1 and chain_prog_in = current bit, for exactly the bit count of this word (WORD_W, or the remainder for the last word) on consecutive cycles.
    - Each shifted 1 increments sent_ones (width clog2(CHAIN_LEN+1)).
    - After the last bit of a non-final word -> WAIT_WORD; this gives one bubble cycle per word.
    - After the last bit of the final word -> VERIFY if VERIFY=1, else DONE.
  - VERIFY: chain_prog_en=1 for exactly CHAIN_LEN cycles. chain_prog_in is driven combinationally from chain_prog_out (recirculation), so chain contents are identical after the pass.
    - At each enabled edge, a 1 on chain_prog_out increments seen_ones.
    - At the end: if seen_ones==sent_ones -> DONE, else -> ERROR.
  - DONE: done=1 and held. busy=0, chain_prog_en=0. start -> new load, clearing done.
  - ERROR: error=1 and held. start -> new load, clearing error.
- chain_prog_en is low in every state except SHIFT and VERIFY. The chain never shifts outside a load.
- All outputs are registered except chain_prog_in during VERIFY, which is a mux on chain_prog_out.
- Simultaneous events:
  - abort has priority over start and over a cfg handshake in the same cycle. Next cycle: IDLE, prog_en=0, cfg_ready=0, done=0, error=0. Chain contents are undefined.
  - start while busy is ignored.
  - cfg_valid outside WAIT_WORD is ignored and no word is consumed.
- Reset mid-operation: immediate IDLE with all outputs 0, per the reset rule.
- Latency: load takes CHAIN_LEN enabled cycles plus one WAIT_WORD cycle per word at minimum. Verify adds CHAIN_LEN cycles. done rises the cycle after the final verify edge.

Test Plan:
- CHAIN_LEN=10, WORD_W=4, VERIFY=1, words 0x5, 0xA, 0x3, 10-cell shift-chain model:
  - chain_prog_in bits while en=1 are 1,0,1,0,0,1,0,1,1,1.
  - en is high exactly 10 cycles in load and 10 in verify.
  - Chain holds the same bits after verify; done=1, error=0, sent_ones=6.
- Same stimulus with chain tail cell stuck at 0 -> error=1, done=0.
- Same stimulus, host holds cfg_valid=0 for 5 cycles before word 1 -> prog_en=0 and cfg_ready=1 during the stall; final result unchanged, done=1.
- abort asserted on the 3rd SHIFT cycle of word 1 -> next cycle IDLE, prog_en=0, cfg_ready=0, busy=0. A later start reloads successfully.
- start pulsed during SHIFT -> ignored, with no extra words requested. prog_rst_n low during VERIFY -> all outputs 0 immediately.
- VERIFY=0, CHAIN_LEN=3, WORD_W=8, word 0xFE -> shifts 0,1,1 only; done one cycle after the 3rd bit; no recirculation cycles.
